hazard_stall_ctrl: RTL

// Central stall/flush controller for the 5-stage pipeline.

---
 rtl/hazard_stall_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: Tuse/Tnew data-hazard
// detection against E/M destinations plus the busy sequencer for the mult/div unit.
module hazard_stall_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic [1:0]       d_tuse_rs,
  input  logic [1:0]       d_tuse_rt,
  input  logic             d_is_md,
  input  logic [4:0]       e_wa,
  input  logic [1:0]       e_tnew,
  input  logic [4:0]       m_wa,
  input  logic [1:0]       m_tnew,
  input  logic             md_start,
  input  logic             md_is_div,
  input  logic             annul_req,
  output logic             stall_pc,
  output logic             stall_fd,
  output logic             flush_de,
  output logic             annul_fd,
  output logic             md_busy,
  output logic             md_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0]       MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0]       DIV_LD  = 4'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       md_cnt_q, md_cnt_d;
  logic             md_err_q, md_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             hz_rs_s, hz_rt_s, hz_md_s, stall_s, md_busy_s;

  // A source stalls only if a producer's result arrives later than it is needed;
  // register 0 never carries a dependency, and Tuse=3 can never be exceeded.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] ewa,
    input logic [1:0] etnew,
    input logic [4:0] mwa,
    input logic [1:0] mtnew
  );
    return (src != 5'd0) &&
           (((src == ewa) && (etnew > tuse)) || ((src == mwa) && (mtnew > tuse)));
  endfunction

  // Hazard detection and the combinational stall/annul/busy outputs.
  always_comb begin
    md_busy_s = (md_cnt_q != 4'd0) || md_start;
    hz_rs_s   = src_hazard(d_rs, d_tuse_rs, e_wa, e_tnew, m_wa, m_tnew);
    hz_rt_s   = src_hazard(d_rt, d_tuse_rt, e_wa, e_tnew, m_wa, m_tnew);
    hz_md_s   = d_is_md && md_busy_s;
    stall_s   = hz_rs_s || hz_rt_s || hz_md_s;
  end

  assign stall_pc  = stall_s;
  assign stall_fd  = stall_s;
  assign flush_de  = stall_s;
  // A stalled delay slot must survive, so stall wins over annul.
  assign annul_fd  = annul_req && !stall_s;
  assign md_busy   = md_busy_s;
  assign md_err    = md_err_q;
  assign stall_cnt = stall_cnt_q;

  // Next-state for the mult/div counter, sticky error flag and stall statistics.
  always_comb begin
    md_cnt_d    = md_cnt_q;
    md_err_d    = md_err_q;
    stall_cnt_d = stall_cnt_q;
    if (reset) begin
      md_cnt_d    = 4'd0;
      md_err_d    = 1'b0;
      stall_cnt_d = {CNT_W{1'b0}};
    end else begin
      if (md_start && (md_cnt_q == 4'd0)) begin
        md_cnt_d = md_is_div ? DIV_LD : MULT_LD;
      end else if (md_cnt_q != 4'd0) begin
        md_cnt_d = md_cnt_q - 4'd1;
      end else begin
        md_cnt_d = md_cnt_q;
      end
      // A start while occupied is dropped; only the error flag records it.
      if (md_start && (md_cnt_q != 4'd0)) begin
        md_err_d = 1'b1;
      end else begin
        md_err_d = md_err_q;
      end
      if (stall_s && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + CNT_ONE;
      end else begin
        stall_cnt_d = stall_cnt_q;
      end
    end
  end

  // State registers; reset is folded into the _d logic above.
  always_ff @(posedge clk) begin
    md_cnt_q    <= md_cnt_d;
    md_err_q    <= md_err_d;
    stall_cnt_q <= stall_cnt_d;
  end

endmodule
